// File: rtl/sme_pkg.sv
// Shared definitions for the SME character feeder: widths, buffer depths,
// the wait-for-result limit and the job FSM state encoding.
package sme_pkg;

  localparam int CHAR_W    = 8;
  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int TIMEOUT   = 255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_STR = 3'd1,
    SEND_PAT = 3'd2,
    WAIT     = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/sme_char_buf.sv
// String (32x8) and pattern (8x8) character storage. One shared write port
// selected by sel (0 = string, 1 = pattern) and one asynchronous read port
// per buffer. Contents are deliberately not reset.
module sme_char_buf
  import sme_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              sel,
  input  logic [4:0]        waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [4:0]        str_raddr,
  output logic [CHAR_W-1:0] str_rdata,
  input  logic [2:0]        pat_raddr,
  output logic [CHAR_W-1:0] pat_rdata
);

  logic [CHAR_W-1:0] str_mem [STR_DEPTH];
  logic [CHAR_W-1:0] pat_mem [PAT_DEPTH];

  // Commit a load into whichever buffer sel addresses.
  always_ff @(posedge clk) begin
    if (we && !sel) str_mem[waddr] <= wdata;
    if (we && sel)  pat_mem[waddr[2:0]] <= wdata;
  end

  assign str_rdata = str_mem[str_raddr];
  assign pat_rdata = pat_mem[pat_raddr];

endmodule

// File: rtl/sme_feeder.sv
// Feeds a stored string and/or pattern to a matching engine one character
// per cycle, then waits for the engine's result (or a timeout) and latches it.
//
// Engine handshake: valid is a single-cycle qualifier for match/match_index.
// It is only consumed while the FSM is in WAIT; at any other time it is
// ignored. There is no back-pressure toward the engine. start is a pulse
// accepted only in IDLE; starts while busy are dropped, not queued.
module sme_feeder
  import sme_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        new_str,
  input  logic [4:0]  str_len_m1,
  input  logic [2:0]  pat_len_m1,
  output logic [7:0]  chardata,
  output logic        isstring,
  output logic        ispattern,
  input  logic        valid,
  input  logic        match,
  input  logic [4:0]  match_index,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [4:0]  found_index,
  output logic        timeout,
  output logic [2:0]  fsm_state
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [4:0]  str_len_q;
  logic [2:0]  pat_len_q;
  logic        capture;
  logic        take_result;
  logic        take_timeout;
  logic [7:0]  str_rdata;
  logic [7:0]  pat_rdata;

  // Loads are only accepted while idle, so a running job sees stable buffers.
  sme_char_buf u_buf (
    .clk       (clk),
    .we        (wr_en && (state == IDLE)),
    .sel       (wr_sel),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .str_raddr (idx),
    .str_rdata (str_rdata),
    .pat_raddr (idx[2:0]),
    .pat_rdata (pat_rdata)
  );

  // FSM state, character index and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Job lengths are sampled together with an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      str_len_q <= '0;
      pat_len_q <= '0;
    end else if (capture) begin
      str_len_q <= str_len_m1;
      pat_len_q <= pat_len_m1;
    end
  end

  // Result registers hold their value until the next job reaches DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found       <= 1'b0;
      found_index <= '0;
      timeout     <= 1'b0;
    end else if (take_result) begin
      found       <= match;
      found_index <= match_index;
      timeout     <= 1'b0;
    end else if (take_timeout) begin
      found       <= 1'b0;
      found_index <= '0;
      timeout     <= 1'b1;
    end
  end

  // Next-state, index/counter update and character stream outputs.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wait_cnt_nxt = '0;
    capture      = 1'b0;
    take_result  = 1'b0;
    take_timeout = 1'b0;
    isstring     = 1'b0;
    ispattern    = 1'b0;
    chardata     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = new_str ? SEND_STR : SEND_PAT;
        end
      end
      SEND_STR: begin
        isstring = 1'b1;
        chardata = str_rdata;
        if (idx == str_len_q) begin
          idx_nxt   = '0;
          state_nxt = SEND_PAT;
        end else begin
          idx_nxt = idx + 5'd1;
        end
      end
      SEND_PAT: begin
        ispattern = 1'b1;
        chardata  = pat_rdata;
        if (idx[2:0] == pat_len_q) begin
          idx_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          idx_nxt = idx + 5'd1;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt + 8'd1;
        // A response arriving on the final allowed cycle still wins.
        if (valid) begin
          take_result = 1'b1;
          state_nxt   = DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          take_timeout = 1'b1;
          state_nxt    = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: a reference copy of both buffers predicts
// the character stream (queued at job start, popped as characters appear),
// and the job result is checked in the DONE cycle and the cycle after.
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start, new_str;
  logic [4:0] str_len_m1;
  logic [2:0] pat_len_m1;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       valid, match;
  logic [4:0] match_index;
  logic       busy, done, found, timeout;
  logic [4:0] found_index;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  logic [9:0] exp_q[$];
  logic [7:0] str_m [32];
  logic [7:0] pat_m [8];

  sme_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .new_str     (new_str),
    .str_len_m1  (str_len_m1),
    .pat_len_m1  (pat_len_m1),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .found_index (found_index),
    .timeout     (timeout),
    .fsm_state   (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input logic sel, input logic [4:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    if (sel) pat_m[addr[2:0]] = data; else str_m[addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic ns, input logic [4:0] sl, input logic [2:0] pl);
    if (ns) for (int i = 0; i <= int'(sl); i++) exp_q.push_back({2'b10, str_m[i]});
    for (int i = 0; i <= int'(pl); i++) exp_q.push_back({2'b01, pat_m[i]});
  endtask

  // Scoreboard: every flagged character must be the next expected one.
  always @(negedge clk) begin
    logic [9:0] e;
    if (done) done_seen++;
    if (isstring && ispattern) begin
      check("flags_exclusive", {isstring, ispattern}, 2'b00);
    end else if (isstring || ispattern) begin
      if (exp_q.size() == 0) begin
        check("unexpected_char", {isstring, ispattern, chardata}, 10'h0);
      end else begin
        e = exp_q.pop_front();
        check("char", {isstring, ispattern, chardata}, e);
      end
    end else begin
      check("idle_chardata", chardata, 8'h00);
    end
  end

  // resp_cyc: WAIT cycle (1-based) on which valid is driven; 0 = never.
  task automatic run_job(input string tag, input logic ns, input logic [4:0] sl,
                         input logic [2:0] pl, input int resp_cyc, input logic m,
                         input logic [4:0] mi, input logic disturb,
                         input logic pre_wr, input logic [2:0] pre_addr,
                         input logic [7:0] pre_data);
    int n_str, n_pat, d0;
    logic e_found, e_to;
    logic [4:0] e_idx;
    n_str = ns ? int'(sl) + 1 : 0;
    n_pat = int'(pl) + 1;
    d0 = done_seen;
    if (pre_wr) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = {2'b00, pre_addr}; wr_data = pre_data;
      pat_m[pre_addr] = pre_data;
    end
    push_exp(ns, sl, pl);
    start = 1'b1; new_str = ns; str_len_m1 = sl; pat_len_m1 = pl;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_busy_first"}, busy, 1'b1);
    check({tag, "_state_first"}, fsm_state, ns ? 32'(sme_pkg::SEND_STR) : 32'(sme_pkg::SEND_PAT));
    for (int c = 0; c < n_str + n_pat; c++) begin
      if (disturb) begin
        wr_en = (c == 1) && (n_str > 1);
        wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'h58;
        start = (c == n_str);
      end
      tick();
    end
    wr_en = 1'b0; start = 1'b0;
    check({tag, "_wait_flags"}, {isstring, ispattern, chardata}, 10'h0);
    check({tag, "_wait_state"}, fsm_state, 32'(sme_pkg::WAIT));
    check({tag, "_all_chars_sent"}, exp_q.size(), 0);
    if (resp_cyc > 0) begin
      for (int i = 1; i < resp_cyc; i++) tick();
      valid = 1'b1; match = m; match_index = mi;
      tick();
      valid = 1'b0;
      e_found = m; e_idx = mi; e_to = 1'b0;
    end else begin
      for (int i = 1; i < 255; i++) tick();
      check({tag, "_no_done_at_255"}, done, 1'b0);
      tick();
      e_found = 1'b0; e_idx = 5'd0; e_to = 1'b1;
    end
    check({tag, "_done"}, {done, busy}, 2'b11);
    check({tag, "_result"}, {found, found_index, timeout}, {e_found, e_idx, e_to});
    tick();
    check({tag, "_after_done"}, {done, busy}, 2'b00);
    check({tag, "_result_held"}, {found, found_index, timeout}, {e_found, e_idx, e_to});
    check({tag, "_one_done_pulse"}, done_seen - d0, 1);
    tick();
    check({tag, "_stays_idle"}, busy, 1'b0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; new_str = 1'b0; str_len_m1 = '0; pat_len_m1 = '0;
    valid = 1'b0; match = 1'b0; match_index = '0;
    tick(); tick();
    check("reset_status", {busy, done, found, found_index, timeout}, 9'h0);
    check("reset_stream", {isstring, ispattern, chardata}, 10'h0);
    check("reset_state", fsm_state, 32'(sme_pkg::IDLE));
    rst = 1'b0;
    tick();

    // "ABCAB" / "CA"
    write_buf(1'b0, 5'd0, 8'h41); write_buf(1'b0, 5'd1, 8'h42); write_buf(1'b0, 5'd2, 8'h43);
    write_buf(1'b0, 5'd3, 8'h41); write_buf(1'b0, 5'd4, 8'h42);
    write_buf(1'b1, 5'd0, 8'h43); write_buf(1'b1, 5'd1, 8'h41);
    run_job("abcab", 1'b1, 5'd4, 3'd1, 3, 1'b1, 5'd2, 1'b0, 1'b0, 3'd0, 8'h00);

    // Result handshake outside WAIT must not disturb the held result.
    valid = 1'b1; match = 1'b0; match_index = 5'd9;
    tick();
    valid = 1'b0;
    check("valid_in_idle", {busy, done, found, found_index, timeout}, {2'b00, 1'b1, 5'd2, 1'b0});

    // Pattern "Z" written in the same cycle as start; pattern-only job.
    run_job("pat_only", 1'b0, 5'd0, 3'd0, 1, 1'b0, 5'd5, 1'b0, 1'b1, 3'd0, 8'h5A);
    run_job("timeout", 1'b0, 5'd0, 3'd0, 0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 8'h00);
    run_job("last_cycle", 1'b0, 5'd0, 3'd0, 255, 1'b1, 5'd7, 1'b0, 1'b0, 3'd0, 8'h00);
    run_job("disturb", 1'b1, 5'd4, 3'd0, 2, 1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 8'h00);
    run_job("buf_kept", 1'b1, 5'd0, 3'd0, 1, 1'b0, 5'd3, 1'b0, 1'b0, 3'd0, 8'h00);

    // Reset in the third SEND_STR cycle aborts without a done pulse.
    write_buf(1'b1, 5'd0, 8'h43); write_buf(1'b1, 5'd1, 8'h41);
    d0 = done_seen;
    push_exp(1'b1, 5'd4, 3'd1);
    start = 1'b1; new_str = 1'b1; str_len_m1 = 5'd4; pat_len_m1 = 3'd1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_abort_state", fsm_state, 32'(sme_pkg::SEND_STR));
    rst = 1'b1;
    #1;
    check("abort_async", {busy, done, isstring, ispattern, chardata}, 12'h0);
    tick();
    check("abort_status", {busy, done, found, found_index, timeout}, 9'h0);
    check("abort_stream", {isstring, ispattern, chardata}, 10'h0);
    exp_q.delete();
    rst = 1'b0;
    tick(); tick();
    check("abort_no_done", done_seen - d0, 0);
    run_job("after_abort", 1'b1, 5'd4, 3'd1, 4, 1'b1, 5'd2, 1'b0, 1'b0, 3'd0, 8'h00);

    // Full-length buffers with random contents.
    for (int i = 0; i < 32; i++) write_buf(1'b0, 5'(i), 8'($urandom_range(255, 1)));
    for (int i = 0; i < 8; i++) write_buf(1'b1, 5'(i), 8'($urandom_range(255, 1)));
    run_job("full_len", 1'b1, 5'd31, 3'd7, 10, 1'b1, 5'd31, 1'b0, 1'b0, 3'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
